// File: rtl/mul_unit.sv
// mul_unit: iterative 32x32 multiplier for MUL, MULH, MULHSU and MULHU.
// Operands are reduced to magnitudes at start and a shift-add loop builds
// the 64-bit unsigned product. A final cycle restores the sign and picks the
// low or high word.
// Optional build macro: MUL_RADIX4_EN retires two multiplier bits per cycle
// (16 CALC cycles) instead of one (32 CALC cycles).
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

`ifdef MUL_RADIX4_EN
  localparam logic [4:0] LAST_COUNT = 5'd15;
`else
  localparam logic [4:0] LAST_COUNT = 5'd31;
`endif

  state_t              state_reg;
  logic [1:0]          op_reg;
  logic                neg_reg;
  logic [XLEN-1:0]     mcand_reg;
  logic [XLEN-1:0]     mplier_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [4:0]          count_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [XLEN-1:0]     result_reg;
`ifdef MUL_RADIX4_EN
  logic [XLEN+1:0]     mcand3_reg;
  logic [XLEN+1:0]     pp_next;
  logic [XLEN+1:0]     sum_next;
  logic [XLEN+1:0]     mcand3_next;
`else
  logic [XLEN:0]       sum_next;
`endif

  logic                sign_a;
  logic                sign_b;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   fixed_acc;

  // Operand signs and magnitudes; MULHU has both operands unsigned, MULHSU only rs2.
  always_comb begin
    sign_a = rs1[XLEN-1] & (op != 2'b11);
    sign_b = rs2[XLEN-1] & ~op[1];
    mag_a  = sign_a ? ({XLEN{1'b0}} - rs1) : rs1;
    mag_b  = sign_b ? ({XLEN{1'b0}} - rs2) : rs2;
  end

`ifdef MUL_RADIX4_EN
  // Radix-4 step: add 0/1x/2x/3x multiplicand into the high half, shift right by two.
  always_comb begin
    mcand3_next = {2'b00, mag_a} + {1'b0, mag_a, 1'b0};
    case (mplier_reg[1:0])
      2'b01:   pp_next = {2'b00, mcand_reg};
      2'b10:   pp_next = {1'b0, mcand_reg, 1'b0};
      2'b11:   pp_next = mcand3_reg;
      default: pp_next = '0;
    endcase
    sum_next = {2'b00, acc_reg[2*XLEN-1:XLEN]} + pp_next;
    acc_next = {sum_next, acc_reg[XLEN-1:2]};
  end
`else
  // Radix-2 step: conditionally add the multiplicand into the high half, shift right by one.
  always_comb begin
    sum_next = {1'b0, acc_reg[2*XLEN-1:XLEN]}
             + (mplier_reg[0] ? {1'b0, mcand_reg} : {(XLEN+1){1'b0}});
    acc_next = {sum_next, acc_reg[XLEN-1:1]};
  end
`endif

  // Sign restoration of the unsigned magnitude product.
  always_comb begin
    fixed_acc = neg_reg ? ({(2*XLEN){1'b0}} - acc_reg) : acc_reg;
  end

  // Control FSM and datapath registers; flush aborts from any state.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
`ifdef MUL_RADIX4_EN
      mcand3_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              op_reg     <= op;
              neg_reg    <= sign_a ^ sign_b;
              mcand_reg  <= mag_a;
              mplier_reg <= mag_b;
              acc_reg    <= '0;
              count_reg  <= '0;
              busy_reg   <= 1'b1;
              state_reg  <= CALC;
`ifdef MUL_RADIX4_EN
              mcand3_reg <= mcand3_next;
`endif
            end
          end
          CALC: begin
            acc_reg   <= acc_next;
`ifdef MUL_RADIX4_EN
            mplier_reg <= {2'b00, mplier_reg[XLEN-1:2]};
`else
            mplier_reg <= {1'b0, mplier_reg[XLEN-1:1]};
`endif
            count_reg <= count_reg + 5'd1;
            if (count_reg == LAST_COUNT) begin
              state_reg <= FIX;
            end
          end
          FIX: begin
            result_reg <= (op_reg == 2'b00) ? fixed_acc[XLEN-1:0]
                                            : fixed_acc[2*XLEN-1:XLEN];
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_mul_unit.sv
// Testbench for mul_unit: directed corner cases plus random operations checked
// against a 64-bit arithmetic reference model.
module tb_mul_unit;

`ifdef MUL_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        clock;
  logic        nreset;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int failures;
  logic [31:0] last_result;

  mul_unit #(.XLEN(32)) dut (
    .clock  (clock),
    .nreset (nreset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: extend each operand per its signedness and take the 64-bit product.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (o != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o <= 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start and return #1 after the sampling edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
  endtask

  // Wait for done, counting edges since the start edge.
  task automatic wait_done(input logic [31:0] exp, input string tag, input int elapsed);
    int n;
    n = elapsed;
    while (!done && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(LAT));
    check({tag, " busy_in_done"}, 64'(busy), 64'd0);
    check({tag, " result"}, 64'(result), 64'(exp));
    last_result = exp;
    @(posedge clock);
    #1;
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    start_op(o, a, b);
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    wait_done(model(o, a, b), tag, 0);
  endtask

  // Watch a window of cycles and report whether done ever rose.
  task automatic expect_no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (done) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] corner [5];
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0;
    failures = 0;
    last_result = 32'd0;
    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
    nreset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clock);
    nreset = 1'b1;

    // Directed arithmetic cases, expected values fixed from hand calculation.
    start_op(2'b00, 32'd7, 32'd6);
    wait_done(32'h0000_002A, "mul_7x6", 0);
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(32'h0000_0000, "mulh_m1xm1", 0);
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(32'h0000_0001, "mul_m1xm1", 0);
    start_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(32'hFFFF_FFFE, "mulhu_max", 0);
    start_op(2'b10, 32'hFFFF_FFFE, 32'd3);
    wait_done(32'hFFFF_FFFF, "mulhsu_m2x3", 0);
    start_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'h8000_0000, "mul_min", 0);
    start_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'h0000_0000, "mulh_min", 0);
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'h7FFF_FFFF, "mulhu_min", 0);

    // Flush mid-CALC: no done, busy drops, result held.
    start_op(2'b00, 32'd5, 32'd5);
    repeat (10) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush result_held", 64'(result), 64'(last_result));
    expect_no_done("flush no_done", 40);
    check("flush result_after", 64'(result), 64'(last_result));

    // Flush together with start in IDLE: nothing starts.
    @(negedge clock);
    flush = 1'b1; start = 1'b1; op = 2'b00; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clock);
    #1;
    flush = 1'b0; start = 1'b0;
    check("flush_start busy", 64'(busy), 64'd0);
    expect_no_done("flush_start no_done", 40);
    run_op(2'b00, 32'd5, 32'd5, "after_flush");

    // Start while busy is ignored.
    start_op(2'b00, 32'd3, 32'd3);
    @(negedge clock);
    start = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(32'h0000_0009, "ignored_start", 1);
    expect_no_done("ignored_start single_done", 40);

    // Asynchronous reset mid-CALC.
    start_op(2'b00, 32'd3, 32'd3);
    repeat (5) @(posedge clock);
    @(negedge clock);
    nreset = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    last_result = 32'd0;
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    expect_no_done("midreset no_done", 40);
    check("midreset result_after", 64'(result), 64'd0);

    // Random operations, some operands drawn from corner values.
    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      run_op(ro, ra, rb, $sformatf("rand%0d op=%0d a=%08h b=%08h", i, ro, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
